// File: rtl/icebus_pkg.sv
// rtl/icebus_pkg.sv - shared constants, state types and helpers for the icebus responder
package icebus_pkg;

   localparam logic [7:0] REQ_HEADER   = 8'hA5;
   localparam logic [7:0] RSP_HEADER   = 8'h5A;
   localparam logic [7:0] BROADCAST_ID = 8'hFF;
   localparam int         REQ_LEN      = 5;
   localparam int         RSP_LEN      = 9;

   typedef enum logic [2:0] {
      P_HUNT,
      P_ID,
      P_SP_HI,
      P_SP_LO,
      P_CSUM
   } parse_state_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_TURN,
      T_PRE,
      T_SEND
   } tx_state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [7:0] rsp_csum(input logic [7:0] id, input logic [31:0] pos,
                                           input logic [15:0] cur);
      return RSP_HEADER ^ id ^ pos[31:24] ^ pos[23:16] ^ pos[15:8] ^ pos[7:0]
             ^ cur[15:8] ^ cur[7:0];
   endfunction

endpackage

// File: rtl/icebus_uart_rx.sv
// rtl/icebus_uart_rx.sv - 8N1 receiver with synchroniser, start-glitch reject and enable gate
module icebus_uart_rx #(
   parameter int CLKS_PER_BIT = 25
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   input  logic       enable,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   output logic       stop_err,
   output logic       active
);
   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   rx_state_t      state;
   logic           rx_meta, rx_sync, rx_prev;
   logic [CW-1:0]  cnt;
   logic [2:0]     bit_idx;

   assign active = (state != R_IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         state    <= R_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         stop_err <= 1'b0;
      end else begin
         rx_meta  <= rx;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         m_tvalid <= 1'b0;
         stop_err <= 1'b0;
         if (!enable) begin
            state <= R_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               R_IDLE: if (rx_prev && !rx_sync) begin
                  state <= R_START;
                  cnt   <= '0;
               end
               // a start bit that is high again at mid-bit was a glitch
               R_START: if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_sync ? R_IDLE : R_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               R_DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                  cnt     <= '0;
                  m_tdata <= {rx_sync, m_tdata[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= R_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               R_STOP: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                  cnt      <= '0;
                  state    <= R_IDLE;
                  m_tvalid <= rx_sync;
                  stop_err <= !rx_sync;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               default: state <= R_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/icebus_responder.sv
// rtl/icebus_responder.sv - icebus node: request parser, setpoint output and status responder
module icebus_responder #(
   parameter int         CLKS_PER_BIT    = 25,
   parameter logic [7:0] NODE_ID         = 8'h00,
   parameter int         TURNAROUND_CLKS = 50,
   parameter int         GAP_BITS        = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx,
   output logic        tx,
   output logic        tx_en,
   input  logic [31:0] position,
   input  logic [15:0] current,
   output logic [15:0] setpoint,
   output logic        setpoint_valid,
   output logic        busy,
   output logic [7:0]  crc_err_cnt,
   output logic [7:0]  frame_err_cnt
);
   import icebus_pkg::*;

   localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
   localparam int GW       = $clog2(GAP_CLKS);

   logic [7:0]   rx_tdata;
   logic         rx_tvalid, rx_stop_err, rx_active;
   parse_state_t pstate;
   logic [7:0]   id_reg, sp_hi, sp_lo, csum_acc;
   logic [GW-1:0] gap_cnt;
   logic         frame_ok;

   tx_state_t    tstate;
   logic [15:0]  tcnt;
   logic [3:0]   bit_idx, byte_idx;
   logic [8:0]   shreg;
   logic [71:0]  rsp_buf;

   // rx is gated while we own the bus so our own echo is never parsed
   icebus_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clock    (clock),
      .reset    (reset),
      .rx       (rx),
      .enable   (!busy),
      .m_tdata  (rx_tdata),
      .m_tvalid (rx_tvalid),
      .stop_err (rx_stop_err),
      .active   (rx_active)
   );

   assign frame_ok = rx_tvalid && (pstate == P_CSUM) && (rx_tdata == csum_acc);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pstate         <= P_HUNT;
         id_reg         <= '0;
         sp_hi          <= '0;
         sp_lo          <= '0;
         csum_acc       <= '0;
         gap_cnt        <= '0;
         setpoint       <= '0;
         setpoint_valid <= 1'b0;
         crc_err_cnt    <= '0;
         frame_err_cnt  <= '0;
      end else begin
         setpoint_valid <= 1'b0;
         if (pstate == P_HUNT || rx_active || rx_tvalid) gap_cnt <= '0;
         else gap_cnt <= gap_cnt + 1'b1;

         if (rx_stop_err) begin
            frame_err_cnt <= sat_inc(frame_err_cnt);
            pstate        <= P_HUNT;
         end else if (rx_tvalid) begin
            csum_acc <= csum_acc ^ rx_tdata;
            case (pstate)
               P_HUNT: if (rx_tdata == REQ_HEADER) begin
                  csum_acc <= rx_tdata;
                  pstate   <= P_ID;
               end
               P_ID: begin
                  id_reg <= rx_tdata;
                  pstate <= (rx_tdata == NODE_ID || rx_tdata == BROADCAST_ID) ? P_SP_HI : P_HUNT;
               end
               P_SP_HI: begin
                  sp_hi  <= rx_tdata;
                  pstate <= P_SP_LO;
               end
               P_SP_LO: begin
                  sp_lo  <= rx_tdata;
                  pstate <= P_CSUM;
               end
               P_CSUM: begin
                  if (frame_ok) begin
                     setpoint       <= {sp_hi, sp_lo};
                     setpoint_valid <= 1'b1;
                  end else begin
                     crc_err_cnt <= sat_inc(crc_err_cnt);
                  end
                  pstate <= P_HUNT;
               end
               default: pstate <= P_HUNT;
            endcase
         end else if (pstate != P_HUNT && gap_cnt == GW'(GAP_CLKS - 1)) begin
            frame_err_cnt <= sat_inc(frame_err_cnt);
            pstate        <= P_HUNT;
         end
      end
   end

   // tx always equals the bit currently on the wire; shreg holds the rest of the byte plus stop
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tstate   <= T_IDLE;
         tx       <= 1'b1;
         tx_en    <= 1'b0;
         busy     <= 1'b0;
         tcnt     <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '1;
         rsp_buf  <= '0;
      end else begin
         case (tstate)
            T_IDLE: if (frame_ok && id_reg != BROADCAST_ID) begin
               busy    <= 1'b1;
               rsp_buf <= {RSP_HEADER, NODE_ID, position, current,
                           rsp_csum(NODE_ID, position, current)};
               tcnt    <= '0;
               tstate  <= T_TURN;
            end
            T_TURN: if (tcnt == 16'(TURNAROUND_CLKS - 1)) begin
               tx_en  <= 1'b1;
               tcnt   <= '0;
               tstate <= T_PRE;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
            T_PRE: if (tcnt == 16'(CLKS_PER_BIT - 1)) begin
               tcnt     <= '0;
               tx       <= 1'b0;
               shreg    <= {1'b1, rsp_buf[71:64]};
               rsp_buf  <= rsp_buf << 8;
               bit_idx  <= '0;
               byte_idx <= '0;
               tstate   <= T_SEND;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
            T_SEND: if (tcnt == 16'(CLKS_PER_BIT - 1)) begin
               tcnt <= '0;
               if (bit_idx == 4'd9) begin
                  bit_idx <= '0;
                  if (byte_idx == 4'(RSP_LEN - 1)) begin
                     tx     <= 1'b1;
                     tx_en  <= 1'b0;
                     busy   <= 1'b0;
                     tstate <= T_IDLE;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     tx       <= 1'b0;
                     shreg    <= {1'b1, rsp_buf[71:64]};
                     rsp_buf  <= rsp_buf << 8;
                  end
               end else begin
                  bit_idx <= bit_idx + 1'b1;
                  tx      <= shreg[0];
                  shreg   <= {1'b1, shreg[8:1]};
               end
            end else begin
               tcnt <= tcnt + 1'b1;
            end
            default: tstate <= T_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icebus_responder.sv
// tb/tb_icebus_responder.sv - directed self-checking bench for icebus_responder
module tb_icebus_responder;
   localparam int CPB  = 25;
   localparam int TURN = 50;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx = 1'b1;
   logic        tx, tx_en, setpoint_valid, busy;
   logic [31:0] position = 32'h00010203;
   logic [15:0] current = 16'h0405;
   logic [15:0] setpoint;
   logic [7:0]  crc_err_cnt, frame_err_cnt;

   int checks = 0;
   int errors = 0;
   int sv_pulses = 0, busy_cycles = 0, tx_low_cycles = 0, turn_cnt = 0, turn_meas = 0;
   logic tx_en_d = 1'b0;

   icebus_responder #(
      .CLKS_PER_BIT(CPB), .NODE_ID(8'h03), .TURNAROUND_CLKS(TURN), .GAP_BITS(20)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .rx             (rx),
      .tx             (tx),
      .tx_en          (tx_en),
      .position       (position),
      .current        (current),
      .setpoint       (setpoint),
      .setpoint_valid (setpoint_valid),
      .busy           (busy),
      .crc_err_cnt    (crc_err_cnt),
      .frame_err_cnt  (frame_err_cnt)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (setpoint_valid) sv_pulses++;
      if (busy) busy_cycles++;
      if (!tx) tx_low_cycles++;
      if (busy && !tx_en) turn_cnt++;
      else if (!busy) turn_cnt = 0;
      if (tx_en && !tx_en_d) turn_meas = turn_cnt;
      tx_en_d = tx_en;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bit_time(input logic v);
      rx = v;
      repeat (CPB) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(stop);
      rx = 1'b1;
   endtask

   task automatic send_req(input logic [7:0] b0, b1, b2, b3, b4);
      send_byte(b0, 1'b1);
      send_byte(b1, 1'b1);
      send_byte(b2, 1'b1);
      send_byte(b3, 1'b1);
      send_byte(b4, 1'b1);
   endtask

   task automatic get_tx_byte(output logic [7:0] b, output logic ok);
      int n = 0;
      ok = 1'b1;
      b  = '0;
      while (tx !== 1'b0 && n < 600) begin
         @(negedge clock);
         n++;
      end
      if (n >= 600) ok = 1'b0;
      else begin
         repeat (CPB / 2) @(negedge clock);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clock);
            b[i] = tx;
         end
         repeat (CPB) @(negedge clock);
         if (tx !== 1'b1) ok = 1'b0;
      end
   endtask

   task automatic wait_busy_low(output logic ok);
      int n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clock);
         n++;
      end
      ok = (n < 3000);
   endtask

   logic [7:0] rsp_exp [9];
   logic [7:0] b;
   logic       ok;
   int         s0, b0, t0, n;

   initial begin
      rsp_exp = '{8'h5A, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h58};

      repeat (3) @(negedge clock);
      check("rst_tx", tx, 1);
      check("rst_tx_en", tx_en, 0);
      check("rst_setpoint", setpoint, 0);
      check("rst_sv", setpoint_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_crc", crc_err_cnt, 0);
      check("rst_frame", frame_err_cnt, 0);
      reset = 1'b0;
      repeat (2 * CPB) @(negedge clock);

      s0 = sv_pulses;
      send_req(8'hA5, 8'h03, 8'h12, 8'h34, 8'h80);
      check("uni_setpoint", setpoint, 16'h1234);
      check("uni_strobe", sv_pulses - s0, 1);
      check("uni_busy", busy, 1);
      for (int i = 0; i < 9; i++) begin
         get_tx_byte(b, ok);
         check("rsp_byte_ok", ok, 1);
         check("rsp_byte", b, rsp_exp[i]);
         if (i == 0) check("rsp_tx_en", tx_en, 1);
      end
      wait_busy_low(ok);
      check("rsp_done", ok, 1);
      check("turnaround", turn_meas, TURN);
      check("rsp_tx_en_low", tx_en, 0);

      s0 = sv_pulses;
      b0 = busy_cycles;
      send_req(8'hA5, 8'h03, 8'h12, 8'h34, 8'h81);
      repeat (4 * CPB) @(negedge clock);
      check("crc_cnt", crc_err_cnt, 1);
      check("crc_setpoint", setpoint, 16'h1234);
      check("crc_strobe", sv_pulses - s0, 0);
      check("crc_busy", busy_cycles - b0, 0);

      s0 = sv_pulses;
      b0 = busy_cycles;
      t0 = tx_low_cycles;
      send_req(8'hA5, 8'hFF, 8'h00, 8'h10, 8'h4A);
      repeat (200) @(negedge clock);
      check("bc_setpoint", setpoint, 16'h0010);
      check("bc_strobe", sv_pulses - s0, 1);
      check("bc_busy", busy_cycles - b0, 0);
      check("bc_tx", tx_low_cycles - t0, 0);

      s0 = sv_pulses;
      send_req(8'hA5, 8'h07, 8'h12, 8'h34, 8'h84);
      repeat (2 * CPB) @(negedge clock);
      check("id7_setpoint", setpoint, 16'h0010);
      check("id7_strobe", sv_pulses - s0, 0);
      check("id7_crc", crc_err_cnt, 1);
      check("id7_frame", frame_err_cnt, 0);

      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h12, 1'b0);
      bit_time(1'b1);
      check("stop_frame", frame_err_cnt, 1);
      s0 = sv_pulses;
      send_req(8'hA5, 8'h03, 8'h56, 8'h78, 8'h88);
      check("after_stop_setpoint", setpoint, 16'h5678);
      check("after_stop_strobe", sv_pulses - s0, 1);
      wait_busy_low(ok);
      check("after_stop_done", ok, 1);
      repeat (2 * CPB) @(negedge clock);

      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      repeat (25 * CPB) @(negedge clock);
      check("gap_frame", frame_err_cnt, 2);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h80, 1'b1);
      repeat (2 * CPB) @(negedge clock);
      check("gap_hunt_setpoint", setpoint, 16'h5678);
      check("gap_hunt_crc", crc_err_cnt, 1);

      s0 = sv_pulses;
      rx = 1'b0;
      repeat (8) @(negedge clock);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clock);
      check("glitch_frame", frame_err_cnt, 2);
      check("glitch_strobe", sv_pulses - s0, 0);
      send_req(8'hA5, 8'hFF, 8'h00, 8'h10, 8'h4A);
      repeat (2 * CPB) @(negedge clock);
      check("glitch_next_setpoint", setpoint, 16'h0010);

      send_req(8'hA5, 8'h03, 8'h9A, 8'hBC, 8'h80);
      n = 0;
      while (tx_en !== 1'b1 && n < 500) begin
         @(negedge clock);
         n++;
      end
      check("send_started", tx_en, 1);
      repeat (300) @(negedge clock);
      reset = 1'b1;
      #1;
      check("arst_tx", tx, 1);
      check("arst_tx_en", tx_en, 0);
      check("arst_busy", busy, 0);
      check("arst_setpoint", setpoint, 0);
      check("arst_crc", crc_err_cnt, 0);
      check("arst_frame", frame_err_cnt, 0);
      repeat (5) @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
